hdmi_hmode_gen: RTL

- Horizontal timing generator; the transmit-side counterpart of the HDMI horizontal-mode measurement logic.
- Takes a 64-bit horizontal mode word {npix, sstart, ssend, htotal}, the same packing the receive path reports.
- Generates per-clock pixel-valid, hsync, horizontal position and a line-start strobe for the HDMI transmit pixel pipeline.
- Mode changes are shadowed and applied only on a line boundary, so no line is ever torn.

---
 rtl/hdmi_hmode_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hdmi_hmode_gen.sv
// Horizontal timing generator: per-clock pixel-valid, hsync, position and line-start strobe
// from a shadowed {npix, sstart, ssend, htotal} mode word. Optional line counter: HDMI_HMODE_GEN_LINECOUNT_EN.
module hdmi_hmode_gen #(
    parameter logic [63:0] INITIAL_HMODE = 64'h0780_07d8_0804_0898,
    parameter logic        HSYNC_ACTIVE  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [63:0] i_hmode,
`ifdef HDMI_HMODE_GEN_LINECOUNT_EN
    input  logic [15:0] i_vtotal,
`endif
    output logic        o_ispix,
    output logic        o_hsync,
    output logic [15:0] o_hpos,
    output logic        o_newline,
    output logic [63:0] o_mode,
    output logic        o_err
`ifdef HDMI_HMODE_GEN_LINECOUNT_EN
    ,
    output logic [15:0] o_vpos,
    output logic        o_newframe
`endif
);

    // state  | meaning
    // IDLE   | out of reset, waiting for the first enabled edge
    // ACTIVE | hpos < npix, pixels valid
    // SHELF  | npix <= hpos < sstart (front porch)
    // SYNC   | sstart <= hpos < ssend, hsync asserted
    // BACK   | ssend <= hpos < htotal (back porch)
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_SHELF,
        ST_SYNC,
        ST_BACK
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hpos_q, hpos_d;
    logic        newline_q, newline_d;
    logic [63:0] mode_q, mode_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        err_q, err_d;
    logic        at_end;
    logic        line_start;

    function automatic logic hmode_ok(input logic [63:0] m);
        logic [15:0] np, ss, se, ht;
        np = m[63:48];
        ss = m[47:32];
        se = m[31:16];
        ht = m[15:0];
        return (np != 16'd0) && (np <= ss) && (ss < se) && (se <= ht);
    endfunction

    function automatic state_t range_state(input logic [15:0] h, input logic [63:0] m);
        state_t s;
        if (h < m[63:48]) begin
            s = ST_ACTIVE;
        end else if (h < m[47:32]) begin
            s = ST_SHELF;
        end else if (h < m[31:16]) begin
            s = ST_SYNC;
        end else begin
            s = ST_BACK;
        end
        return s;
    endfunction

    // widened so htotal = 16'hffff cannot alias through the +1
    assign at_end = ({1'b0, hpos_q} + 17'd1) == {1'b0, mode_q[15:0]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            hpos_q     <= 16'd0;
            newline_q  <= 1'b0;
            mode_q     <= INITIAL_HMODE;
            pend_q     <= 64'd0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hpos_q     <= hpos_d;
            newline_q  <= newline_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hpos_d     = hpos_q;
        newline_d  = 1'b0;
        mode_d     = mode_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = err_q;
        line_start = 1'b0;
        if (i_en) begin
            if (state_q == ST_IDLE || at_end) begin
                line_start = 1'b1;
                hpos_d     = 16'd0;
                state_d    = ST_ACTIVE;
                newline_d  = 1'b1;
                if (pend_vld_q) begin
                    mode_d     = pend_q;
                    pend_vld_d = 1'b0;
                end
            end else begin
                hpos_d  = hpos_q + 16'd1;
                state_d = range_state(hpos_d, mode_q);
            end
        end
        // evaluated after the line-boundary apply so a load on a wrap edge stays pending
        if (i_load) begin
            if (hmode_ok(i_hmode)) begin
                pend_d     = i_hmode;
                pend_vld_d = 1'b1;
                err_d      = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        o_ispix   = (state_q == ST_ACTIVE);
        o_hsync   = (state_q == ST_SYNC) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
        o_hpos    = hpos_q;
        o_newline = newline_q;
        o_mode    = mode_q;
        o_err     = err_q;
    end

`ifdef HDMI_HMODE_GEN_LINECOUNT_EN
    logic [15:0] vpos_q, vpos_d;
    logic        newframe_q, newframe_d;
    logic        v_at_end;

    assign v_at_end = (i_vtotal == 16'd0) ||
                      (({1'b0, vpos_q} + 17'd1) == {1'b0, i_vtotal});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vpos_q     <= 16'd0;
            newframe_q <= 1'b0;
        end else begin
            vpos_q     <= vpos_d;
            newframe_q <= newframe_d;
        end
    end

    always_comb begin
        vpos_d     = vpos_q;
        newframe_d = 1'b0;
        if (line_start) begin
            if (state_q == ST_IDLE || v_at_end) begin
                vpos_d     = 16'd0;
                newframe_d = 1'b1;
            end else begin
                vpos_d = vpos_q + 16'd1;
            end
        end
    end

    assign o_vpos     = vpos_q;
    assign o_newframe = newframe_q;
`endif

endmodule
